// File: rtl/main_mem_arbiter.sv
// Single-port main memory arbiter: data port first, fetch anti-starvation.
// Optional grant statistics are compiled in with MEM_ARB_STATS_EN.
module main_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] if_grant_cnt,
  output logic [STAT_W-1:0] dm_grant_cnt,
  output logic [STAT_W-1:0] starve_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  owner_t            rsp_owner;
  logic [ADDR_W-1:0] last_addr;
  logic              forced;

  // Grant decision and memory drive for the current cycle
  always_comb begin
    forced   = (wait_cnt == WAIT_MAX);
    if_gnt   = rst_n & if_req & (~dm_req | forced);
    dm_gnt   = rst_n & dm_req & ~(if_req & forced);
    mem_we   = dm_gnt & dm_we;
    mem_addr = last_addr;
    unique case (1'b1)
      if_gnt:  mem_addr = if_addr;
      dm_gnt:  mem_addr = dm_addr;
      default: mem_addr = last_addr;
    endcase
  end

  assign mem_wdata = dm_wdata;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign if_rvalid = (rsp_owner == OWN_IF);
  assign dm_rvalid = (rsp_owner == OWN_DM);

  // Fetch starvation counter, cleared by a grant or a withdrawn request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Remember who owns next cycle's read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= OWN_NONE;
    end else if (if_gnt) begin
      rsp_owner <= OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      rsp_owner <= OWN_DM;
    end else begin
      rsp_owner <= OWN_NONE;
    end
  end

  // Hold the last granted address on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
    end else if (if_gnt || dm_gnt) begin
      last_addr <= mem_addr;
    end
  end

`ifdef MEM_ARB_STATS_EN
  localparam logic [STAT_W-1:0] CNT_MAX = '1;

  logic starve_evt;
  assign starve_evt = if_gnt & dm_req & forced;

  // Saturating grant statistics; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
      starve_cnt   <= '0;
    end else if (stats_clr) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
      starve_cnt   <= '0;
    end else begin
      if (if_gnt && if_grant_cnt != CNT_MAX)
        if_grant_cnt <= if_grant_cnt + 1'b1;
      if (dm_gnt && dm_grant_cnt != CNT_MAX)
        dm_grant_cnt <= dm_grant_cnt + 1'b1;
      if (starve_evt && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Shares the single-port 8K x 16 main memory between the instruction-fetch port (IF) and the data-memory port (DM).
- Grants at most one access per cycle and drives the memory's write-enable/address/data inputs.
- Routes the one-cycle-latency read data back to the port that issued the read.
- Sits between the CPU front-end/load-store unit and MainMemory. Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 16, memory word width
MAX_WAIT, 4, consecutive denied IF cycles before IF is forced to win (1..15)
STAT_W, 16, width of grant counters (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rdata  out  DATA_W  fetch read data
if_rvalid  out  1  if_rdata valid
dm_req  in  1  data request, held until dm_gnt
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data request accepted this cycle
dm_rdata  out  DATA_W  data read data
dm_rvalid  out  1  dm_rdata valid (reads only)
mem_we  out  1  to memory write enable
mem_addr  out  ADDR_W  to memory address
mem_wdata  out  DATA_W  to memory data in
mem_rdata  in  DATA_W  from memory data out, valid 1 cycle after read issue

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low. While rst_n=0: if_gnt=0, dm_gnt=0, if_rvalid=0, dm_rvalid=0, mem_we=0, wait_cnt=0, rsp_owner=NONE.
- Grant decision is combinational in the request cycle. The memory samples mem_* on the next rising edge. Requesters drop or advance req after seeing gnt high at that edge.
- Priority:
  - Only one req high: that port wins.
  - Both high: DM wins, unless wait_cnt==MAX_WAIT, in which case IF wins.
- wait_cnt (4 bits):
  - Increments when if_req=1 and if_gnt=0.
  - Clears on if_gnt=1 or if_req=0.
  - Saturates at MAX_WAIT.
- Memory drive:
  - mem_addr = winner's address; mem_wdata = dm_wdata always.
  - mem_we = dm_gnt & dm_we; mem_we=0 when no grant.
  - With no request, mem_addr holds the last granted address (registered copy; 0 after reset).
- Response tracking: rsp_owner register set at each edge to IF (IF granted), DM (DM read granted), or NONE (DM write or idle).
  - if_rvalid = (rsp_owner==IF); dm_rvalid = (rsp_owner==DM).
  - Read latency: 1 cycle after grant.
  - Both rdata outputs = mem_rdata (unregistered); consumers qualify with rvalid.
- Writes: acknowledged by dm_gnt only; no dm_rvalid.
- Back-to-back: a new grant is allowed every cycle, including the cycle in which the previous read's rvalid is high. Throughput is 1 access/cycle.
- Read-after-write, same address: a read granted in the cycle after the write returns the new data.
- Reset mid-operation: pending rvalid is dropped. No rvalid appears in the first cycle after rst_n deasserts.
- Request withdrawn without grant: permitted; no side effects beyond clearing wait_cnt for IF.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds outputs if_grant_cnt[STAT_W-1:0], dm_grant_cnt[STAT_W-1:0], starve_cnt[STAT_W-1:0], plus input stats_clr.
  - Grant counters increment per grant. starve_cnt increments on each forced IF win.
  - All counters saturate at all-ones, clear on reset or stats_clr=1. stats_clr has priority over increment in the same cycle.
- Undefined: the ports and logic are absent; core arbitration is identical.

Test Plan:
- Reset: rst_n=0 with if_req=dm_req=1 -> all gnt/rvalid/mem_we=0; release -> IF/DM served from next cycle, no spurious rvalid.
- IF only: if_addr=0x0010 read, memory preloaded 0xBEEF -> if_gnt=1 same cycle, if_rvalid=1 with if_rdata=0xBEEF next cycle.
- DM write then read: write 0x1234 to 0x1FFF, next cycle read 0x1FFF -> dm_gnt both cycles, mem_we=1 only first, dm_rvalid=1 with 0x1234 in third cycle.
- Contention, MAX_WAIT=4, both req held continuously -> DM granted 4 cycles, IF on 5th, pattern repeats; if_rvalid exactly one cycle after each IF grant.
- Async reset asserted in cycle after IF read grant -> if_rvalid never asserts; wait_cnt=0 after release.
- MEM_ARB_STATS_EN: 10 IF, 6 DM grants, 1 forced win, then stats_clr -> counters read 10/6/1, then 0/0/0.
